// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the registered 1-to-N demultiplexer.
//   mode_e        : per-beat routing mode encodings
//   is_addr_mode  : true for modes that route by in_sel (reserved folds here)
// ----------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic [1:0] {
        MODE_ADDR  = 2'b00,
        MODE_BCAST = 2'b01,
        MODE_RR    = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // The reserved encoding behaves exactly like addressed routing.
    function automatic logic is_addr_mode(input logic [1:0] m);
        return (m == MODE_ADDR) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// ----------------------------------------------------------------------------
// demux_out_slot
// One-entry holding register for a single output channel.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : capture i_data this edge (sets valid)
//   i_data       : payload to capture
//   i_ready      : downstream consumer ready
//   o_valid      : slot holds a beat
//   o_data       : held payload (keeps last value after draining)
//   o_free       : slot can accept a load this edge
// ----------------------------------------------------------------------------
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A full slot whose consumer takes the beat this cycle can be refilled
    // on the same edge.
    assign o_free  = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_n_reg.sv
// ----------------------------------------------------------------------------
// demux_1_n_reg
// Registered 1-to-N demultiplexer with valid/ready flow control. Each input
// beat goes to one addressed channel, to all channels, or to the next channel
// in rotation. Every channel has its own one-entry slot so a stalled consumer
// only blocks beats aimed at it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   mode       : 00 addressed, 01 broadcast, 10 round-robin, 11 = addressed
//   in_valid   : producer beat present
//   in_ready   : beat accepted this cycle (combinational, never from in_valid)
//   in_data    : beat payload
//   in_sel     : addressed target channel
//   out_valid  : per-channel beat present
//   out_ready  : per-channel consumer ready
//   out_data   : channel k at [k*WIDTH +: WIDTH]
//   err_sel    : one-cycle pulse after an out-of-range addressed beat is dropped
//   rr_ptr     : next round-robin target
// ----------------------------------------------------------------------------
module demux_1_n_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   err_sel,
    output logic [SEL_W-1:0]       rr_ptr
);

    logic [SEL_W-1:0] r_rr;
    logic             r_err;

    logic [N_OUT-1:0] w_free;
    logic [N_OUT-1:0] w_hit_addr;
    logic [N_OUT-1:0] w_hit_rr;
    logic [N_OUT-1:0] w_target;
    logic [N_OUT-1:0] w_load;
    logic             w_is_addr;
    logic             w_sel_ok;
    logic             w_accept;

    assign w_is_addr = is_addr_mode(mode);
    assign w_sel_ok  = ({1'b0, in_sel} < (SEL_W+1)'(N_OUT));

    always_comb begin
        w_hit_addr = '0;
        w_hit_rr   = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_hit_addr[k] = (in_sel == SEL_W'(k));
            w_hit_rr[k]   = (r_rr   == SEL_W'(k));
        end
    end

    // Target set for the beat currently offered. An out-of-range addressed
    // beat targets nothing, which makes it accepted and silently dropped.
    always_comb begin
        w_target = '0;
        if (mode == MODE_BCAST) begin
            w_target = '1;
        end else if (mode == MODE_RR) begin
            w_target = w_hit_rr;
        end else if (w_sel_ok) begin
            w_target = w_hit_addr;
        end
    end

    // Ready when every targeted slot can take the beat; blocked in reset.
    assign in_ready = rst_n & ((w_target & ~w_free) == '0);
    assign w_accept = in_valid & in_ready;
    assign w_load   = w_accept ? w_target : '0;

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_slot
            demux_out_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[g]),
                .i_data  (in_data),
                .i_ready (out_ready[g]),
                .o_valid (out_valid[g]),
                .o_data  (out_data[g*WIDTH +: WIDTH]),
                .o_free  (w_free[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr  <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & w_is_addr & ~w_sel_ok;
            if (w_accept && (mode == MODE_RR)) begin
                // Explicit wrap so non-power-of-two channel counts rotate correctly.
                if (r_rr == SEL_W'(N_OUT-1)) begin
                    r_rr <= '0;
                end else begin
                    r_rr <= r_rr + SEL_W'(1);
                end
            end
        end
    end

    assign rr_ptr  = r_rr;
    assign err_sel = r_err;

endmodule

// File: tb/tb_demux_1_n_reg.sv
module tb_demux_1_n_reg;

    localparam int NN [2] = '{4, 3};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0] t_mode  [2];
    logic       t_valid [2];
    logic [1:0] t_sel   [2];
    logic [7:0] t_data  [2];
    logic [3:0] t_ordy  [2];

    logic        rdy4, rdy3, err4, err3;
    logic [1:0]  rr4, rr3;
    logic [3:0]  o4_valid;
    logic [31:0] o4_data;
    logic [2:0]  o3_valid;
    logic [23:0] o3_data;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: per-channel "holding a beat" flag and payload.
    bit       m_vld [2][4];
    bit [7:0] m_dat [2][4];
    int       m_rr  [2];
    bit       m_err [2];

    always #5 clk = ~clk;

    demux_1_n_reg #(.WIDTH(8), .N_OUT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .mode(t_mode[0]), .in_valid(t_valid[0]),
        .in_ready(rdy4), .in_data(t_data[0]), .in_sel(t_sel[0]),
        .out_valid(o4_valid), .out_ready(t_ordy[0]), .out_data(o4_data),
        .err_sel(err4), .rr_ptr(rr4)
    );

    demux_1_n_reg #(.WIDTH(8), .N_OUT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .mode(t_mode[1]), .in_valid(t_valid[1]),
        .in_ready(rdy3), .in_data(t_data[1]), .in_sel(t_sel[1]),
        .out_valid(o3_valid), .out_ready(t_ordy[1][2:0]), .out_data(o3_data),
        .err_sel(err3), .rr_ptr(rr3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A channel can take a beat when it is empty or its consumer drains it now.
    function automatic bit can_take(input int d, input int k);
        return !m_vld[d][k] || t_ordy[d][k];
    endfunction

    function automatic bit exp_rdy(input int d);
        bit r;
        if (!rst_n) return 1'b0;
        case (t_mode[d])
            2'b01: begin
                r = 1'b1;
                for (int k = 0; k < NN[d]; k++) r = r && can_take(d, k);
                return r;
            end
            2'b10:   return can_take(d, m_rr[d]);
            default: return (int'(t_sel[d]) >= NN[d]) ? 1'b1 : can_take(d, int'(t_sel[d]));
        endcase
    endfunction

    always @(negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                m_vld[d][k] = 1'b0;
                m_dat[d][k] = 8'h00;
            end
            m_rr[d]  = 0;
            m_err[d] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                bit acc;
                bit is_rr, is_bc, is_ad;
                acc   = t_valid[d] && exp_rdy(d);
                is_bc = (t_mode[d] == 2'b01);
                is_rr = (t_mode[d] == 2'b10);
                is_ad = !is_bc && !is_rr;
                for (int k = 0; k < NN[d]; k++)
                    if (m_vld[d][k] && t_ordy[d][k]) m_vld[d][k] = 1'b0;
                m_err[d] = 1'b0;
                if (acc) begin
                    if (is_bc) begin
                        for (int k = 0; k < NN[d]; k++) begin
                            m_vld[d][k] = 1'b1;
                            m_dat[d][k] = t_data[d];
                        end
                    end else if (is_rr) begin
                        m_vld[d][m_rr[d]] = 1'b1;
                        m_dat[d][m_rr[d]] = t_data[d];
                        m_rr[d] = (m_rr[d] + 1) % NN[d];
                    end else if (int'(t_sel[d]) < NN[d]) begin
                        m_vld[d][t_sel[d]] = 1'b1;
                        m_dat[d][t_sel[d]] = t_data[d];
                    end else if (is_ad) begin
                        m_err[d] = 1'b1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [3:0]  dv [2];
        logic [31:0] dd [2];
        logic        dr [2], de [2];
        logic [1:0]  dp [2];
        dv[0] = o4_valid;          dv[1] = {1'b0, o3_valid};
        dd[0] = o4_data;           dd[1] = {8'h00, o3_data};
        dr[0] = rdy4;              dr[1] = rdy3;
        de[0] = err4;              de[1] = err3;
        dp[0] = rr4;               dp[1] = rr3;
        for (int d = 0; d < 2; d++) begin
            logic [3:0] ev;
            ev = '0;
            for (int k = 0; k < NN[d]; k++) begin
                ev[k] = m_vld[d][k];
                chk($sformatf("m%0d_data%0d", d, k), {24'h0, dd[d][k*8 +: 8]}, {24'h0, m_dat[d][k]});
            end
            chk($sformatf("m%0d_valid", d), {28'h0, dv[d]}, {28'h0, ev});
            chk($sformatf("m%0d_ready", d), {31'h0, dr[d]}, {31'h0, exp_rdy(d)});
            chk($sformatf("m%0d_err", d), {31'h0, de[d]}, {31'h0, m_err[d]});
            chk($sformatf("m%0d_rr", d), {30'h0, dp[d]}, 32'(m_rr[d]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            t_mode[d] = 2'b00; t_valid[d] = 1'b0; t_sel[d] = 2'd0;
            t_data[d] = 8'h00; t_ordy[d] = 4'hF;
        end
        #1;
        chk("rst_valid", {28'h0, o4_valid}, 32'h0);
        chk("rst_ready", {31'h0, rdy4}, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Addressed sweep
        for (int k = 0; k < 4; k++) begin
            t_mode[0] = 2'b00; t_valid[0] = 1'b1; t_sel[0] = 2'(k); t_data[0] = 8'hA0 + 8'(k);
            cyc(1);
            chk("sweep_vld", {28'h0, o4_valid}, 32'h1 << k);
            chk("sweep_dat", {24'h0, o4_data[k*8 +: 8]}, 32'hA0 + 32'(k));
        end
        t_valid[0] = 1'b0;
        cyc(1);
        chk("sweep_drain", {28'h0, o4_valid}, 32'h0);

        // Backpressure on channel 2
        t_ordy[0] = 4'b1011;
        t_valid[0] = 1'b1; t_sel[0] = 2'd2; t_data[0] = 8'h11;
        cyc(1);
        t_data[0] = 8'h22;
        #1 chk("bp_stall", {31'h0, rdy4}, 32'h0);
        cyc(2);
        chk("bp_stall2", {31'h0, rdy4}, 32'h0);
        t_sel[0] = 2'd1; t_data[0] = 8'h33;
        #1 chk("bp_other", {31'h0, rdy4}, 32'h1);
        cyc(1);
        chk("bp_other_dat", {24'h0, o4_data[15:8]}, 32'h33);
        t_sel[0] = 2'd2; t_data[0] = 8'h22; t_ordy[0] = 4'hF;
        #1 chk("bp_release", {31'h0, rdy4}, 32'h1);
        chk("bp_held", {24'h0, o4_data[23:16]}, 32'h11);
        cyc(1);
        chk("bp_refill_v", {31'h0, o4_valid[2]}, 32'h1);
        chk("bp_refill_d", {24'h0, o4_data[23:16]}, 32'h22);
        t_valid[0] = 1'b0;
        cyc(1);

        // Broadcast blocked by a full slot 3
        t_ordy[0] = 4'b0111;
        t_valid[0] = 1'b1; t_sel[0] = 2'd3; t_data[0] = 8'h77;
        cyc(1);
        t_mode[0] = 2'b01; t_data[0] = 8'h5A;
        #1 chk("bc_block", {31'h0, rdy4}, 32'h0);
        cyc(2);
        t_ordy[0] = 4'hF;
        #1 chk("bc_release", {31'h0, rdy4}, 32'h1);
        cyc(1);
        chk("bc_vld", {28'h0, o4_valid}, 32'hF);
        chk("bc_dat", o4_data, 32'h5A5A5A5A);
        t_valid[0] = 1'b0;
        cyc(1);

        // Round-robin wrap over four channels
        t_mode[0] = 2'b10; t_valid[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            t_data[0] = 8'(i + 1);
            cyc(1);
            chk("rr_vld", {28'h0, o4_valid}, 32'h1 << (i % 4));
            chk("rr_dat", {24'h0, o4_data[(i%4)*8 +: 8]}, 32'(i + 1));
        end
        t_valid[0] = 1'b0;
        cyc(1);
        chk("rr_ptr_end", {30'h0, rr4}, 32'h2);

        // Illegal select and three-channel rotation on the N_OUT=3 instance
        t_mode[1] = 2'b00; t_valid[1] = 1'b1; t_sel[1] = 2'd3; t_data[1] = 8'h99;
        #1 chk("ill_ready", {31'h0, rdy3}, 32'h1);
        cyc(1);
        chk("ill_err", {31'h0, err3}, 32'h1);
        chk("ill_vld", {29'h0, o3_valid}, 32'h0);
        t_valid[1] = 1'b0;
        cyc(1);
        chk("ill_err_end", {31'h0, err3}, 32'h0);
        t_mode[1] = 2'b10; t_valid[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t_data[1] = 8'h30 + 8'(i);
            cyc(1);
            chk("rr3_vld", {29'h0, o3_valid}, 32'h1 << (i % 3));
        end
        t_valid[1] = 1'b0;
        cyc(1);
        chk("rr3_ptr", {30'h0, rr3}, 32'h1);

        // Reset while slots 0 and 2 hold beats
        t_mode[0] = 2'b00; t_ordy[0] = 4'b1010; t_valid[0] = 1'b1;
        t_sel[0] = 2'd0; t_data[0] = 8'hC0;
        cyc(1);
        t_sel[0] = 2'd2; t_data[0] = 8'hC2;
        cyc(1);
        t_valid[0] = 1'b0;
        chk("pre_rst_vld", {28'h0, o4_valid}, 32'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {28'h0, o4_valid}, 32'h0);
        chk("mid_rst_dat", o4_data, 32'h0);
        chk("mid_rst_rr", {30'h0, rr4}, 32'h0);
        chk("mid_rst_rdy", {31'h0, rdy4}, 32'h0);
        cyc(1);
        rst_n = 1'b1;
        t_ordy[0] = 4'hF; t_valid[0] = 1'b1; t_sel[0] = 2'd0; t_data[0] = 8'hE1;
        cyc(1);
        chk("post_rst_vld", {28'h0, o4_valid}, 32'h1);
        chk("post_rst_dat", {24'h0, o4_data[7:0]}, 32'hE1);
        t_valid[0] = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
